// File: rtl/matrix_writer.sv
// matrix_writer
// Captures a TileRows x TileCols signed tile on start and writes it, one
// element per granted cycle, into a row-major matrix held in a single-port
// memory. The memory port may be shared with a reader, so every write waits
// for mem_gnt_i.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   start_i              start request, honoured only when idle
//   base_addr_i          matrix base address           (captured on start)
//   matrix_cols_i        row stride in elements        (captured on start)
//   start_row_i/_col_i   tile top-left position        (captured on start)
//   matrix_i             tile data                     (captured on start)
//   busy_o               high while the tile is being written
//   done_o               one-cycle pulse after the last element commits
//   mem_gnt_i            a write commits on an edge with mem_we_o & mem_gnt_i
//   mem_addr_o/_we_o/_wr_data_o  registered memory write port
module matrix_writer #(
   parameter int AddrWidth = 8,
   parameter int DataWidth = 8,
   parameter int TileRows  = 4,
   parameter int TileCols  = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic [AddrWidth-1:0]        base_addr_i,
   input  logic [15:0]                 matrix_cols_i,
   input  logic [15:0]                 start_row_i,
   input  logic [15:0]                 start_col_i,
   input  logic signed [DataWidth-1:0] matrix_i [0:TileRows-1][0:TileCols-1],
   output logic                        busy_o,
   output logic                        done_o,
   input  logic                        mem_gnt_i,
   output logic [AddrWidth-1:0]        mem_addr_o,
   output logic                        mem_we_o,
   output logic signed [DataWidth-1:0] mem_wr_data_o
);

   localparam int RW = (TileRows > 1) ? $clog2(TileRows) : 1;
   localparam int CW = (TileCols > 1) ? $clog2(TileCols) : 1;
   localparam logic [RW-1:0] RMax = RW'(TileRows - 1);
   localparam logic [CW-1:0] CMax = CW'(TileCols - 1);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

   state_e                      state_q, state_d;
   logic [RW-1:0]               r_q, r_d;
   logic [CW-1:0]               c_q, c_d;
   // row_base holds the address of element (r,0): base + (row+r)*cols + col
   logic [AddrWidth-1:0]        row_base_q, row_base_d;
   logic [AddrWidth-1:0]        cols_q, cols_d;
   logic signed [DataWidth-1:0] tile_q [0:TileRows-1][0:TileCols-1];
   logic signed [DataWidth-1:0] tile_d [0:TileRows-1][0:TileCols-1];
   logic [AddrWidth-1:0]        addr_q, addr_d;
   logic signed [DataWidth-1:0] data_q, data_d;
   logic                        we_q, we_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;

   logic [RW-1:0]        r_inc;
   logic [CW-1:0]        c_inc;
   logic [AddrWidth-1:0] first_addr;

   assign r_inc = r_q + RW'(1);
   assign c_inc = c_q + CW'(1);

   // Start offset is multiplied once at full width, then wrapped to the
   // address space; per-element addresses are pure adds after that.
   assign first_addr = AddrWidth'(32'(base_addr_i)
                                  + 32'(start_row_i) * 32'(matrix_cols_i)
                                  + 32'(start_col_i));

   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      c_d        = c_q;
      row_base_d = row_base_q;
      cols_d     = cols_q;
      tile_d     = tile_q;
      addr_d     = addr_q;
      data_d     = data_q;
      we_d       = we_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               tile_d     = matrix_i;
               cols_d     = AddrWidth'(matrix_cols_i);
               row_base_d = first_addr;
               r_d        = '0;
               c_d        = '0;
               addr_d     = first_addr;
               data_d     = matrix_i[0][0];
               we_d       = 1'b1;
               busy_d     = 1'b1;
               state_d    = WRITE;
            end
         end
         WRITE: begin
            // Without a grant everything holds, so the port stays stable.
            if (mem_gnt_i) begin
               if (r_q == RMax && c_q == CMax) begin
                  we_d    = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (c_q == CMax) begin
                  c_d        = '0;
                  r_d        = r_inc;
                  row_base_d = row_base_q + cols_q;
                  addr_d     = row_base_q + cols_q;
                  data_d     = tile_q[r_inc][0];
               end else begin
                  c_d    = c_inc;
                  addr_d = row_base_q + AddrWidth'(c_inc);
                  data_d = tile_q[r_q][c_inc];
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         r_q        <= '0;
         c_q        <= '0;
         row_base_q <= '0;
         cols_q     <= '0;
         for (int i = 0; i < TileRows; i++)
            for (int j = 0; j < TileCols; j++)
               tile_q[i][j] <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         c_q        <= c_d;
         row_base_q <= row_base_d;
         cols_q     <= cols_d;
         tile_q     <= tile_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign mem_addr_o    = addr_q;
   assign mem_wr_data_o = data_q;
   assign mem_we_o      = we_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_matrix_writer.sv
// Scoreboard bench for matrix_writer: stimulus pushes expected writes computed
// from the address formula; a negedge monitor pops them as the DUT commits.
module tb_matrix_writer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic gnt = 1'b0;
   logic [7:0] base = '0;
   logic [15:0] cols = '0, srow = '0, scol = '0;
   logic signed [7:0] mat [0:3][0:3];
   logic busy, done, we;
   logic [7:0] addr;
   logic signed [7:0] wdata;

   matrix_writer #(.AddrWidth(8), .DataWidth(8), .TileRows(4), .TileCols(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base),
      .matrix_cols_i(cols), .start_row_i(srow), .start_col_i(scol),
      .matrix_i(mat), .busy_o(busy), .done_o(done), .mem_gnt_i(gnt),
      .mem_addr_o(addr), .mem_we_o(we), .mem_wr_data_o(wdata));

   always #5 clk = ~clk;

   typedef struct packed { logic [7:0] a; logic signed [7:0] d; } wr_t;
   wr_t exp_q[$];
   logic signed [7:0] mem [0:255];
   logic signed [7:0] exp_mem [0:255];
   int n_cmp = 0, n_fail = 0;
   logic held_v = 1'b0;
   logic [7:0] held_a;
   logic signed [7:0] held_d;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: commits happen on the next posedge when we && gnt.
   always @(negedge clk) begin
      wr_t e;
      if (rst_n) begin
         if (held_v) begin
            check("stall_hold_addr", int'(addr), int'(held_a));
            check("stall_hold_data", int'(wdata), int'(held_d));
            check("stall_hold_we", int'(we), 1);
         end
         held_v = we && !gnt;
         held_a = addr;
         held_d = wdata;
         if (we && gnt) begin
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("wr_addr", int'(addr), int'(e.a));
               check("wr_data", int'(wdata), int'(e.d));
            end
            mem[addr] = wdata;
         end
      end else held_v = 1'b0;
   end

   task automatic clear_mems();
      for (int i = 0; i < 256; i++) begin
         mem[i] = '0;
         exp_mem[i] = '0;
      end
   endtask

   // Reference: addr(r,c) = base + (srow+r)*cols + (scol+c) mod 256.
   // Only the first n_mem elements land in the expected memory image.
   task automatic load_model(input int n_mem);
      int unsigned a;
      int k;
      k = 0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            a = (int'(base) + (int'(srow) + r) * int'(cols) + int'(scol) + c) % 256;
            exp_q.push_back('{a: a[7:0], d: mat[r][c]});
            if (k < n_mem) exp_mem[a] = mat[r][c];
            k++;
         end
   endtask

   task automatic cmp_mem(input string name);
      int bad;
      bad = -1;
      for (int i = 255; i >= 0; i--) if (mem[i] !== exp_mem[i]) bad = i;
      if (bad < 0) check(name, 0, 0);
      else check(name, int'(mem[bad]) * 1000 + bad, int'(exp_mem[bad]) * 1000 + bad);
   endtask

   task automatic seq_tile();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) mat[r][c] = 8'(r * 4 + c + 1);
   endtask

   task automatic rand_tile();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) mat[r][c] = 8'($urandom);
   endtask

   // mode 0: grant tied high, 1: fixed stall pattern, 2: random grant,
   // 3: grant high plus a start pulse mid-run and tile changed after start.
   task automatic run(input int mode, input int exp_done);
      int done_edge, busy_cnt, stalls;
      clear_mems();
      @(posedge clk); #1;
      start = 1'b1;
      gnt = 1'b1;
      load_model(16);
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 3) rand_tile();
      done_edge = -1;
      stalls = 0;
      busy_cnt = int'(busy);
      for (int k = 1; k <= 300; k++) begin
         case (mode)
            1: gnt = !(k inside {3, 4, 5, 19, 20});
            2: gnt = ($urandom_range(0, 3) != 0);
            default: gnt = 1'b1;
         endcase
         start = (mode == 3 && k == 7);
         if (!gnt) stalls++;
         @(posedge clk); #1;
         if (done) begin
            done_edge = k;
            break;
         end
         busy_cnt += int'(busy);
      end
      start = 1'b0;
      gnt = 1'b1;
      if (exp_done >= 0) check("done_latency", done_edge, exp_done);
      else check("done_latency", done_edge, 16 + stalls);
      check("busy_cycles", busy_cnt, 16 + stalls);
      check("busy_low_at_done", int'(busy), 0);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      @(posedge clk); #1;
      check("done_pulse_width", int'(done), 0);
      cmp_mem("mem_contents");
   endtask

   initial begin
      seq_tile();
      clear_mems();
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_we", int'(we), 0);
      check("rst_addr", int'(addr), 0);
      check("rst_data", int'(wdata), 0);
      @(negedge clk); rst_n = 1'b1;

      // Basic tile at (0,0)
      base = 8'h00; cols = 16; srow = 0; scol = 0; seq_tile();
      run(0, 16);
      // Offset tile at (3,3)
      srow = 3; scol = 3;
      run(0, 16);
      // Stride 8, nonzero base
      base = 8'h10; cols = 8; srow = 1; scol = 2;
      run(0, 16);
      // Grant stalls on edges 3-5 and twice on the final element
      base = 8'h00; cols = 16; srow = 0; scol = 0;
      run(1, 21);
      // Address wrap, ignored mid-run start, tile change after capture
      base = 8'hF0; rand_tile();
      run(3, 16);
      // Zero stride: rows overwrite the same four words
      base = 8'h20; cols = 0; srow = 5; scol = 1; rand_tile();
      run(2, -1);
      // Random configurations and random grant
      for (int t = 0; t < 4; t++) begin
         base = 8'($urandom); cols = 16'($urandom_range(0, 40));
         srow = 16'($urandom_range(0, 300)); scol = 16'($urandom_range(0, 300));
         rand_tile();
         run(2, -1);
      end

      // Reset during the 6th write cycle: only elements 0-4 committed
      clear_mems();
      base = 8'h00; cols = 16; srow = 0; scol = 0; seq_tile();
      @(posedge clk); #1;
      start = 1'b1; gnt = 1'b1;
      load_model(5);
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("mid_rst_we", int'(we), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_addr", int'(addr), 0);
      check("mid_rst_data", int'(wdata), 0);
      check("mid_rst_pending", exp_q.size(), 11);
      exp_q.delete();
      @(negedge clk); #1 rst_n = 1'b1;
      cmp_mem("mid_rst_mem");
      // Normal operation after reset
      run(0, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
